// File: rtl/crypto_pkg.sv
`default_nettype none
// ============================================================================
// Module      : crypto_pkg
// Description : Shared types, constants and rotate helpers for the Speck unit.
// Revision    : 1.0 - initial release
// ============================================================================
package crypto_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    KEYEXP = 2'd1,
    RUN    = 2'd2,
    DONE   = 2'd3
  } crypto_state_e;

  localparam int ROUNDS_DEFAULT = 22;
  localparam int ALPHA          = 7;
  localparam int BETA           = 2;

  // Same encoding as the decoder's encrypt/decrypt select.
  localparam logic CRYPTO_ENC = 1'b0;
  localparam logic CRYPTO_DEC = 1'b1;

  localparam logic [6:0] OPCODE_ENCRY = 7'b0011100;
  localparam logic [2:0] FUNC3_ENC    = 3'b010;
  localparam logic [2:0] FUNC3_DEC    = 3'b011;

  function automatic logic [15:0] ror16(input logic [15:0] v, input int amt);
    logic [31:0] t;
    t = {v, v} >> amt;
    return t[15:0];
  endfunction

  function automatic logic [15:0] rol16(input logic [15:0] v, input int amt);
    logic [31:0] t;
    t = {v, v} << amt;
    return t[31:16];
  endfunction

endpackage
`default_nettype wire

// File: rtl/speck_round.sv
`default_nettype none
// ============================================================================
// Module      : speck_round
// Description : One combinational Speck32/64 round, forward or inverse.
// Revision    : 1.0 - initial release
// ============================================================================
module speck_round
  import crypto_pkg::*;
(
  input  logic [15:0] x_i,
  input  logic [15:0] y_i,
  input  logic [15:0] k_i,
  input  logic        dec_i,
  output logic [15:0] x_next_o,
  output logic [15:0] y_next_o
);

  logic [15:0] x_enc, y_enc;
  logic [15:0] x_dec, y_dec;

  always_comb begin
    x_enc = (ror16(x_i, ALPHA) + y_i) ^ k_i;
    y_enc = rol16(y_i, BETA) ^ x_enc;
    // Inverse round: recover y first, since x's inverse needs the old y.
    y_dec = ror16(y_i ^ x_i, BETA);
    x_dec = rol16((x_i ^ k_i) - y_dec, ALPHA);
  end

  assign x_next_o = (dec_i == CRYPTO_ENC) ? x_enc : x_dec;
  assign y_next_o = (dec_i == CRYPTO_ENC) ? y_enc : y_dec;

endmodule
`default_nettype wire

// File: rtl/otter_crypto_unit.sv
`default_nettype none
// ============================================================================
// Module      : otter_crypto_unit
// Description : Multi-cycle Speck32/64 encrypt/decrypt unit with key expansion.
// Revision    : 1.0 - initial release
// ============================================================================
module otter_crypto_unit
  import crypto_pkg::*;
#(
  parameter int ROUNDS = ROUNDS_DEFAULT,
  parameter int WORD_W = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  start,
  input  logic                  crypto_sel,
  input  logic [2*WORD_W-1:0]   data_in,
  input  logic                  key_wr,
  input  logic [4*WORD_W-1:0]   key_in,
  output logic                  busy,
  output logic                  done,
  output logic [2*WORD_W-1:0]   data_out,
  output logic                  key_valid,
  output logic                  key_err
);

  localparam int                IW   = $clog2(ROUNDS);
  localparam logic [IW-1:0]     LAST = IW'(ROUNDS - 1);
  localparam logic [IW-1:0]     LAST_KEY_STEP = IW'(ROUNDS - 2);

  crypto_state_e       state_q;
  logic [WORD_W-1:0]   rk_q [ROUNDS];
  logic [WORD_W-1:0]   l0_q, l1_q, l2_q;
  logic [WORD_W-1:0]   x_q, y_q;
  logic [IW-1:0]       i_q, r_q;
  logic                dec_q, err_q;
  logic                busy_q, done_q, key_valid_q, key_err_q;
  logic [2*WORD_W-1:0] data_out_q;

  logic [WORD_W-1:0]   l_new_d, rk_next_d, k_d, x_next_d, y_next_d;
  logic [IW-1:0]       rk_idx_d;

  always_comb begin
    l_new_d   = (rk_q[i_q] + ror16(l0_q, ALPHA)) ^ WORD_W'(i_q);
    rk_next_d = rol16(rk_q[i_q], BETA) ^ l_new_d;
    rk_idx_d  = (dec_q == CRYPTO_DEC) ? (LAST - r_q) : r_q;
    k_d       = rk_q[rk_idx_d];
  end

  speck_round u_round (
    .x_i      (x_q),
    .y_i      (y_q),
    .k_i      (k_d),
    .dec_i    (dec_q),
    .x_next_o (x_next_d),
    .y_next_o (y_next_d)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      key_err_q   <= 1'b0;
      key_valid_q <= 1'b0;
      data_out_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      key_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (key_wr) begin
            rk_q[0]     <= key_in[WORD_W-1:0];
            l0_q        <= key_in[2*WORD_W-1:WORD_W];
            l1_q        <= key_in[3*WORD_W-1:2*WORD_W];
            l2_q        <= key_in[4*WORD_W-1:3*WORD_W];
            i_q         <= '0;
            key_valid_q <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= KEYEXP;
          end else if (start) begin
            x_q   <= data_in[2*WORD_W-1:WORD_W];
            y_q   <= data_in[WORD_W-1:0];
            dec_q <= (crypto_sel == CRYPTO_DEC);
            r_q   <= '0;
            if (key_valid_q) begin
              err_q   <= 1'b0;
              busy_q  <= 1'b1;
              state_q <= RUN;
            end else begin
              // No key: the operand is echoed back with key_err.
              err_q   <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        KEYEXP: begin
          rk_q[i_q + IW'(1)] <= rk_next_d;
          l0_q <= l1_q;
          l1_q <= l2_q;
          l2_q <= l_new_d;
          i_q  <= i_q + IW'(1);
          if (i_q == LAST_KEY_STEP) begin
            key_valid_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        RUN: begin
          x_q <= x_next_d;
          y_q <= y_next_d;
          r_q <= r_q + IW'(1);
          if (r_q == LAST) begin
            busy_q  <= 1'b0;
            state_q <= DONE;
          end
        end
        DONE: begin
          data_out_q <= {x_q, y_q};
          done_q     <= 1'b1;
          key_err_q  <= err_q;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign data_out  = data_out_q;
  assign key_valid = key_valid_q;
  assign key_err   = key_err_q;

endmodule
`default_nettype wire

// File: tb/tb_otter_crypto_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_otter_crypto_unit
// Description : Scoreboard bench for otter_crypto_unit using Speck32/64 vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_otter_crypto_unit;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        start = 1'b0;
  logic        crypto_sel = 1'b0;
  logic [31:0] data_in = '0;
  logic        key_wr = 1'b0;
  logic [63:0] key_in = '0;
  logic        busy, done, key_valid, key_err;
  logic [31:0] data_out;

  otter_crypto_unit dut (
    .CLK        (CLK),
    .RST        (RST),
    .start      (start),
    .crypto_sel (crypto_sel),
    .data_in    (data_in),
    .key_wr     (key_wr),
    .key_in     (key_in),
    .busy       (busy),
    .done       (done),
    .data_out   (data_out),
    .key_valid  (key_valid),
    .key_err    (key_err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  localparam logic [63:0] KEY = 64'h1918_1110_0908_0100;
  localparam logic [31:0] PT  = 32'h6574_694C;
  localparam logic [31:0] CT  = 32'hA868_42F2;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest expected response.
  always @(negedge CLK) begin
    if (!RST && done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("data_out", 64'(data_out), 64'(e.data));
        chk("key_err", 64'(key_err), 64'(e.err));
        chk("latency_cycle", 64'(cyc), 64'(e.due));
      end
    end else if (!RST && key_err) begin
      chk("key_err_without_done", 64'd1, 64'd0);
    end
  end

  task automatic issue_start(input logic [31:0] d, input logic sel,
                             input logic [31:0] exp_d, input logic exp_err, input int lat);
    exp_t e;
    e.data = exp_d;
    e.err  = exp_err;
    e.due  = cyc + 1 + lat;
    sb.push_back(e);
    data_in    = d;
    crypto_sel = sel;
    start      = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
  endtask

  task automatic drain(input int budget);
    for (int k = 0; k < budget && sb.size() > 0; k++) @(posedge CLK);
    #1;
    if (sb.size() != 0) begin
      chk("done_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k_edge;

    // Reset state
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_key_err", 64'(key_err), 64'd0);
    chk("rst_key_valid", 64'(key_valid), 64'd0);
    chk("rst_data_out", 64'(data_out), 64'd0);
    @(posedge CLK); #1;
    RST = 1'b0;
    idle(2);

    // Start with no key loaded: operand echoed, key_err with done
    issue_start(32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 1'b1, 1);
    drain(20);

    // Key load: busy for 21 cycles, then key_valid
    key_in = KEY;
    key_wr = 1'b1;
    k_edge = cyc + 1;
    @(posedge CLK); #1;
    key_wr = 1'b0;
    for (int t = 1; t <= 21; t++) begin
      @(negedge CLK);
      chk("keyexp_busy", 64'(busy), 64'((cyc - k_edge) < 21));
      chk("keyexp_key_valid", 64'(key_valid), 64'((cyc - k_edge) >= 21));
    end
    @(posedge CLK); #1;

    // Known-answer encrypt and decrypt
    issue_start(PT, 1'b0, CT, 1'b0, 23);
    @(negedge CLK);
    chk("run_busy", 64'(busy), 64'd1);
    drain(40);
    issue_start(CT, 1'b1, PT, 1'b0, 23);
    drain(40);

    // Start during RUN is ignored
    issue_start(PT, 1'b0, CT, 1'b0, 23);
    idle(5);
    data_in = 32'h1111_2222;
    start   = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    drain(40);
    idle(6);
    chk("data_out_held", 64'(data_out), 64'(CT));

    // key_wr and start together: key reload wins, no done
    key_wr     = 1'b1;
    start      = 1'b1;
    data_in    = 32'h0BAD_F00D;
    @(posedge CLK); #1;
    key_wr = 1'b0;
    start  = 1'b0;
    @(negedge CLK);
    chk("collide_busy", 64'(busy), 64'd1);
    chk("collide_key_valid", 64'(key_valid), 64'd0);
    idle(25);
    chk("reload_key_valid", 64'(key_valid), 64'd1);
    chk("reload_data_out_held", 64'(data_out), 64'(CT));

    // Reset mid-RUN before round 10 completes
    issue_start(PT, 1'b0, CT, 1'b0, 23);
    idle(10);
    RST = 1'b1;
    void'(sb.pop_back());
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_key_valid", 64'(key_valid), 64'd0);
    chk("abort_data_out", 64'(data_out), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    idle(30);
    issue_start(32'h1234_5678, 1'b0, 32'h1234_5678, 1'b1, 1);
    drain(20);
    idle(3);

    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
